// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory req/ack bus for LW/SW, stalls upstream
// while an access is outstanding, and registers the MEM/WB payload.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   alu_result_i, store_data_i, rsd_i, Op_i, valid_i   EX/MEM inputs
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o       memory request
//   mem_rdata_i, mem_ack_i                             memory response
//   stall_o                                            hold EX/MEM and earlier
//   wb_data_o, rsd_o, reg_write_o, valid_o, err_o      MEM/WB payload
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        rsd_i,
    input  logic [2:0]        Op_i,
    input  logic              valid_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic [31:0]       wb_data_o,
    output logic [4:0]        rsd_o,
    output logic              reg_write_o,
    output logic              valid_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        abort_q;
    logic        is_mem;
    logic        misal;

    assign is_mem = valid_i & ((Op_i == 3'b010) | (Op_i == 3'b011));
    assign misal  = |alu_result_i[1:0];

    // A misaligned op never enters ACCESS, so it must not stall.
    // Gated with rst_i so reset releases upstream without waiting for an edge.
    assign stall_o = rst_i & is_mem &
                     (((state_q == IDLE) & ~misal) | (state_q == ACCESS));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (is_mem & ~misal) state_d = ACCESS;
            ACCESS:  if (mem_ack_i | (cnt_q == LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            abort_q     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wb_data_o   <= '0;
            rsd_o       <= '0;
            reg_write_o <= 1'b0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
            err_o       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!is_mem) begin
                        wb_data_o   <= alu_result_i;
                        rsd_o       <= rsd_i;
                        valid_o     <= valid_i;
                        reg_write_o <= valid_i & (Op_i[2:1] == 2'b00) &
                                       (|rsd_i);
                    end else if (misal) begin
                        wb_data_o <= '0;
                        rsd_o     <= rsd_i;
                        valid_o   <= 1'b1;
                        err_o     <= 1'b1;
                    end else begin
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= {alu_result_i[ADDR_W-1:2], 2'b00};
                        mem_we_o    <= (Op_i == 3'b011);
                        mem_wdata_o <= store_data_i;
                        cnt_q       <= '0;
                        abort_q     <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) rdata_q <= mem_rdata_i;
                    end else if (cnt_q == LAST) begin
                        mem_req_o <= 1'b0;
                        abort_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    valid_o     <= 1'b1;
                    rsd_o       <= rsd_i;
                    err_o       <= abort_q;
                    wb_data_o   <= (abort_q | mem_we_o) ? '0 : rdata_q;
                    reg_write_o <= ~mem_we_o & ~abort_q & (|rsd_i);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed plan steps followed by random ops,
// each checked against a transaction-level expectation.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  rsd_i = '0;
    logic [2:0]  Op_i = '0;
    logic        valid_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o;
    logic [31:0] wb_data_o;
    logic [4:0]  rsd_o;
    logic        reg_write_o;
    logic        valid_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .rsd_i(rsd_i), .Op_i(Op_i), .valid_i(valid_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .wb_data_o(wb_data_o), .rsd_o(rsd_o),
        .reg_write_o(reg_write_o), .valid_o(valid_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction from issue to MEM/WB. lat = cycle in ACCESS on which
    // ack arrives (1 = first); lat > T means the access times out.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rsd,
                          input logic vld, input int lat,
                          input logic [31:0] rd);
        bit memop;
        bit ld;
        bit aligned;
        bit abort;
        int n;
        memop   = vld && (op == 3'b010 || op == 3'b011);
        ld      = (op == 3'b010);
        aligned = (addr[1:0] == 2'b00);
        Op_i = op;
        alu_result_i = addr;
        store_data_i = sd;
        rsd_i = rsd;
        valid_i = vld;
        mem_ack_i = 1'($urandom);
        mem_rdata_i = $urandom;
        #1;
        chk("stall_issue", 32'(stall_o), 32'(memop && aligned));
        if (!memop || !aligned) begin
            @(negedge clk_i);
            chk("pt_valid", 32'(valid_o), 32'(memop ? 1'b1 : vld));
            chk("pt_err", 32'(err_o), 32'(memop));
            chk("pt_wb", wb_data_o, memop ? 32'd0 : addr);
            chk("pt_rsd", 32'(rsd_o), 32'(rsd));
            chk("pt_rw", 32'(reg_write_o),
                32'(!memop && vld && op <= 3'd1 && rsd != 5'd0));
            chk("pt_req", 32'(mem_req_o), 32'd0);
            return;
        end
        n = (lat < T) ? lat : T;
        abort = (lat > T);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            chk("acc_req", 32'(mem_req_o), 32'd1);
            chk("acc_addr", mem_addr_o, {addr[31:2], 2'b00});
            chk("acc_we", 32'(mem_we_o), 32'(op == 3'b011));
            chk("acc_wdata", mem_wdata_o, sd);
            chk("acc_valid", 32'(valid_o), 32'd0);
            chk("acc_err", 32'(err_o), 32'd0);
            chk("acc_stall", 32'(stall_o), 32'd1);
            alu_result_i = $urandom;
            store_data_i = $urandom;
            mem_ack_i = (k == lat - 1);
            mem_rdata_i = (k == lat - 1) ? rd : $urandom;
        end
        @(negedge clk_i);
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_valid", 32'(valid_o), 32'd0);
        mem_ack_i = 1'($urandom);
        mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("wb_valid", 32'(valid_o), 32'd1);
        chk("wb_err", 32'(err_o), 32'(abort));
        chk("wb_rsd", 32'(rsd_o), 32'(rsd));
        chk("wb_rw", 32'(reg_write_o),
            32'(ld && !abort && rsd != 5'd0));
        if (ld || abort) chk("wb_data", wb_data_o, abort ? 32'd0 : rd);
        chk("wb_req", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rw", 32'(reg_write_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ALU pass-through
        run_op(3'b000, 32'h15, 32'h0, 5'd5, 1'b1, 1, 32'h0);
        // LW, ack on the third ACCESS cycle
        run_op(3'b010, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEADBEEF);
        // SW, store data scrambled mid-access
        run_op(3'b011, 32'h24, 32'h1234, 5'd3, 1'b1, 2, 32'h0);
        // misaligned LW
        run_op(3'b010, 32'h102, 32'h0, 5'd7, 1'b1, 1, 32'h0);
        // timeout, then non-mem op with possible stray ack
        run_op(3'b010, 32'h200, 32'h0, 5'd9, 1'b1, 100, 32'h0);
        run_op(3'b001, 32'h33, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        // invalid slot
        run_op(3'b000, 32'h44, 32'h0, 5'd4, 1'b0, 1, 32'h0);

        // reset during ACCESS
        Op_i = 3'b010;
        alu_result_i = 32'h300;
        rsd_i = 5'd8;
        valid_i = 1'b1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("pre_rst_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        chk("rst_hold_err", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        run_op(3'b010, 32'h300, 32'h0, 5'd8, 1'b1, 1, 32'hCAFEF00D);
        run_op(3'b010, 32'h304, 32'h0, 5'd0, 1'b1, 2, 32'h11112222);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op(3'($urandom_range(0, 7)), a, $urandom,
                   5'($urandom), ($urandom_range(0, 7) != 0),
                   int'($urandom_range(1, 6)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX/MEM buffer outputs and drives the data-memory request/acknowledge interface for loads and stores.
- Stalls upstream stages while a memory access is outstanding.
- Registers the write-back payload for the MEM/WB buffer.
- Non-memory ops pass through with one cycle of latency and no stall.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS waiting for mem_ack_i before the access is aborted (1..255).
- ADDR_W, 32: data-memory address width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-low reset.
- alu_result_i  in  32  ALU result; memory byte address for load/store.
- store_data_i  in  32  store data (forwarded rs2 value).
- rsd_i  in  5  destination register index.
- Op_i  in  3  op class: 000 R-ALU, 001 I-ALU, 010 LW, 011 SW, 100 BEQ; others are no-op.
- valid_i  in  1  instruction in EX/MEM is valid.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word-aligned byte address.
- mem_wdata_o  out  32  store data.
- mem_rdata_i  in  32  load data; valid when mem_ack_i=1.
- mem_ack_i  in  1  access complete.
- stall_o  out  1  hold the EX/MEM buffer and all earlier stages.
- wb_data_o  out  32  write-back value.
- rsd_o  out  5  write-back register.
- reg_write_o  out  1  register-file write enable.
- valid_o  out  1  MEM/WB payload valid.
- err_o  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; timeout counter=0.
  - All outputs 0, including mem_req_o, stall_o and valid_o.
  - Reset asserted mid-access drops mem_req_o immediately. The aborted access produces no valid_o and no err_o.
- Mem op: valid_i=1 and Op_i in {010, 011}.
- stall_o (combinational) = mem op present AND state != DONE. It is never asserted for non-mem ops.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Non-mem op: next posedge registers wb_data_o=alu_result_i, rsd_o=rsd_i, valid_o=valid_i. reg_write_o=valid_i & (Op_i in {000, 001}) & (rsd_i != 0).
  - Mem op with alu_result_i[1:0]!=0 (misaligned):
    - No request is issued; stall_o=0 that cycle.
    - Next posedge: valid_o=1, reg_write_o=0, wb_data_o=0, err_o=1.
  - Aligned mem op: next posedge sets state=ACCESS, mem_req_o=1, mem_addr_o={alu_result_i[ADDR_W-1:2], 2'b00}, mem_we_o=(Op_i==011), mem_wdata_o=store_data_i, counter=0, valid_o=0.
- ACCESS:
  - mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are held stable.
  - mem_ack_i=1: mem_req_o<=0; for LW, capture mem_rdata_i; state<=DONE.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with no ack: mem_req_o<=0, the abort flag is set, state<=DONE.
  - mem_ack_i sampled in IDLE or DONE is ignored.
- DONE (one cycle):
  - stall_o=0, so upstream advances on this edge.
  - Posedge registers valid_o=1 and rsd_o.
  - LW: wb_data_o=captured data; reg_write_o=(rsd_i!=0) & ~abort.
  - SW: reg_write_o=0.
  - Abort: err_o=1 and wb_data_o=0.
  - state<=IDLE.
- Back-to-back mem ops:
  - Each costs at least 3 cycles: IDLE→ACCESS, ack, DONE.
  - The next op is evaluated in IDLE on the following cycle.
- valid_i=0 in IDLE: valid_o<=0 and reg_write_o<=0.
- err_o, valid_o and reg_write_o are each valid for exactly one cycle per instruction.
- valid_o=0 on every posedge where state is ACCESS, or where state is IDLE and an aligned mem op is starting.
- Store data and address are latched at request start. Upstream changes during ACCESS do not affect the bus.

Test Plan:
1. ALU pass-through: Op_i=000, alu_result_i=0x0000_0015, rsd_i=5, valid_i=1 -> next cycle: wb_data_o=0x15, rsd_o=5, reg_write_o=1, valid_o=1; stall_o stays 0.
2. LW with ack after 3 cycles: addr 0x100, mem_rdata_i=0xDEADBEEF, rsd_i=7 -> mem_req_o high 3 cycles with mem_addr_o=0x100 and mem_we_o=0; stall_o high until DONE; then wb_data_o=0xDEADBEEF, reg_write_o=1, rsd_o=7.
3. SW: addr 0x24, store_data_i=0x1234 -> mem_we_o=1, mem_wdata_o=0x1234 held through ACCESS; store_data_i changed mid-access does not alter mem_wdata_o; completion gives valid_o=1, reg_write_o=0.
4. Misaligned LW at 0x102 -> mem_req_o never asserted, stall_o=0, err_o pulses one cycle, reg_write_o=0.
5. Timeout with TIMEOUT_CYCLES=4 and no ack -> mem_req_o drops after 4 cycles in ACCESS; err_o=1, reg_write_o=0, wb_data_o=0; a late mem_ack_i in IDLE is ignored.
6. rst_i=0 asserted during ACCESS -> mem_req_o, stall_o and valid_o go to 0 immediately (no edge needed); after release, a fresh LW completes normally; LW to rsd_i=0 gives reg_write_o=0.
